// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32x32 MIPS register file, two read ports, one write port, write-first bypass
module mips_reg_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_OUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    input  logic [ADDR_W-1:0] Write_reg,
    input  logic [DATA_W-1:0] Write_data,
    input  logic              RegWrite,
    input  logic              Read_en,
    output logic [DATA_W-1:0] Read_data1,
    output logic [DATA_W-1:0] Read_data2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_hit;
    logic [DATA_W-1:0] port1_value;
    logic [DATA_W-1:0] port2_value;

    // Writes to $0 are dropped here so the storage entry never holds anything but zero.
    assign write_hit = RegWrite && (Write_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[Write_reg] <= Write_data;
        end
    end

    // Write-first: a value being written this cycle is what the ALU sees.
    always_comb begin
        port1_value = regs[Read_reg1];
        if (Read_reg1 == '0) begin
            port1_value = '0;
        end else if (RegWrite && (Write_reg == Read_reg1)) begin
            port1_value = Write_data;
        end
    end

    always_comb begin
        port2_value = regs[Read_reg2];
        if (Read_reg2 == '0) begin
            port2_value = '0;
        end else if (RegWrite && (Write_reg == Read_reg2)) begin
            port2_value = Write_data;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_registered
            logic [DATA_W-1:0] data1_q;
            logic [DATA_W-1:0] data2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data1_q <= '0;
                    data2_q <= '0;
                end else if (Read_en) begin
                    data1_q <= port1_value;
                    data2_q <= port2_value;
                end
            end

            assign Read_data1 = data1_q;
            assign Read_data2 = data2_q;
        end else begin : g_combinational
            logic unused_read_en;
            assign unused_read_en = Read_en;

            // Gate with reset so the bypass path cannot leak Write_data while in reset.
            assign Read_data1 = rst_n ? port1_value : '0;
            assign Read_data2 = rst_n ? port2_value : '0;
        end
    endgenerate

endmodule
